// File: rtl/eth_tx_arbiter_if.sv
// Bus between the user/engine side and the Ethernet TX arbiter.
// master: the arbiter itself; slave: the sources, engines and GMII consumer.
interface eth_tx_arbiter_if;
  logic [2:0]  src_start;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [2:0]  eng_txd_valid;
  logic [23:0] eng_txd_data;
  logic        gmii_txd_valid;
  logic [7:0]  gmii_txd_data;
  logic [2:0]  grant;
  logic [2:0]  pend;
  logic        busy;
  logic        tx_timeout;

  modport master (
    input  src_start, eng_done, eng_txd_valid, eng_txd_data,
    output eng_start, gmii_txd_valid, gmii_txd_data, grant, pend, busy, tx_timeout
  );

  modport slave (
    output src_start, eng_done, eng_txd_valid, eng_txd_data,
    input  eng_start, gmii_txd_valid, gmii_txd_data, grant, pend, busy, tx_timeout
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Grants one TX engine (ARP/ICMP/UDP) at a time onto the shared GMII path, with inter-frame gap.
// Define TX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYC     = 12,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input logic              clk,
  input logic              reset,
  eth_tx_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_IFG   = 2'd3;

  localparam logic [15:0] IFG_LAST     = 16'(IFG_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  winner;
  logic [15:0] cnt_q, cnt_d;
  logic        txd_valid_q, txd_valid_d;
  logic [7:0]  txd_data_q, txd_data_d;
  logic [2:0]  eng_start;
  logic        done_g;
  logic        valid_g;
  logic [7:0]  data_g;
  logic        timeout_hit;

`ifdef TX_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] rr_idx;

  // Scan from lowest to highest priority so the highest-priority match is assigned last.
  always_comb begin
    winner = 3'b000;
    rr_idx = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      rr_idx = 2'((int'(ptr_q) + k) % 3);
      if (pend_q[rr_idx]) winner = 3'b001 << rr_idx;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_START) begin
      ptr_d = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd2;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    if (pend_q[0])      winner = 3'b001;
    else if (pend_q[1]) winner = 3'b010;
    else if (pend_q[2]) winner = 3'b100;
    else                winner = 3'b000;
  end
`endif

  assign eng_start = (state_q == ST_START) ? grant_q : 3'b000;
  assign done_g    = |(bus.eng_done & grant_q);
  assign valid_g   = |(bus.eng_txd_valid & grant_q);
  assign data_g    = ({8{grant_q[0]}} & bus.eng_txd_data[7:0])
                   | ({8{grant_q[1]}} & bus.eng_txd_data[15:8])
                   | ({8{grant_q[2]}} & bus.eng_txd_data[23:16]);

  // A done arriving on the last allowed cycle suppresses the timeout.
  assign timeout_hit = (state_q == ST_SEND) && (cnt_q == TIMEOUT_LAST) && !done_g;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 3'b000) begin
          grant_d = winner;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = 16'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        cnt_d = cnt_q + 16'd1;
        if (done_g || timeout_hit) begin
          grant_d = 3'b000;
          cnt_d   = 16'd0;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request in the same cycle as its start re-queues one further frame.
  always_comb begin
    pend_d      = (pend_q & ~eng_start) | bus.src_start;
    txd_valid_d = (state_q == ST_SEND) && valid_g;
    txd_data_d  = (state_q == ST_SEND) ? data_g : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= 3'b000;
      grant_q     <= 3'b000;
      cnt_q       <= 16'd0;
      txd_valid_q <= 1'b0;
      txd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      txd_valid_q <= txd_valid_d;
      txd_data_q  <= txd_data_d;
    end
  end

  assign bus.eng_start      = eng_start;
  assign bus.gmii_txd_valid = txd_valid_q;
  assign bus.gmii_txd_data  = txd_data_q;
  assign bus.grant          = grant_q;
  assign bus.pend           = pend_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.tx_timeout     = timeout_hit;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus a randomized phase,
// checked every cycle against a frame-level timing model of the arbiter.
module tb_eth_tx_arbiter;
  localparam int IFG       = 12;
  localparam int TO        = 100;
  localparam int NEVER     = -1;
  localparam int NEVER_RUN = 150;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  eth_tx_arbiter_if bus ();

  eth_tx_arbiter #(
    .IFG_CYC     (IFG),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [2:0] req        = 3'b000;
  logic [2:0] force_done = 3'b000;
  bit         rst_req    = 1'b1;
  bit         noise_en   = 1'b0;
  bit         rand_len   = 1'b0;

  int e_len[3];
  bit e_run[3];
  int e_pos[3];

  // Model: frame in flight (owner, start cycle) and earliest cycle a new pick may happen.
  logic [2:0] m_pend;
  bit         m_active;
  int         t_start;
  int         owner;
  int         ready;
  int         m_last;
  logic       exp_gv;
  logic [7:0] exp_gd;

  int starts_seen[3];
  int last_start_cyc[3];
  int timeouts_seen;
  int order_q[$];

`ifdef TX_ARB_RR_EN
  int exp_order[4] = '{0, 1, 2, 0};
`else
  int exp_order[4] = '{0, 0, 1, 2};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic [2:0] p, input int last);
`ifdef TX_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (p[(last + k) % 3]) return (last + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (p[k]) return k;
    if (last < 0) return -1;
`endif
    return -1;
  endfunction

  task automatic cycle();
    logic [2:0]  v, dn, src, es, exp_start, exp_grant;
    logic [23:0] d;
    logic        exp_busy, exp_to;
    int          lim;
    @(negedge clk);
    v  = 3'b000;
    dn = 3'b000;
    d  = 24'h0;
    for (int i = 0; i < 3; i++) begin
      if (e_run[i]) begin
        lim = (e_len[i] == NEVER) ? NEVER_RUN : e_len[i];
        if (e_pos[i] < lim) begin
          v[i] = 1'b1;
          d[8*i +: 8] = 8'($urandom);
          e_pos[i]++;
        end else begin
          dn[i]    = (e_len[i] != NEVER);
          e_run[i] = 1'b0;
        end
      end else if (noise_en) begin
        v[i] = 1'($urandom);
        d[8*i +: 8] = 8'($urandom);
        dn[i] = ($urandom_range(0, 7) == 0);
      end
    end
    dn = dn | force_done;
    force_done = 3'b000;
    src = req;
    req = 3'b000;
    reset = rst_req;
    bus.src_start     = src;
    bus.eng_txd_valid = v;
    bus.eng_txd_data  = d;
    bus.eng_done      = dn;
    #1;
    if (rst_req) begin
      exp_start = 3'b000; exp_grant = 3'b000; exp_busy = 1'b0; exp_to = 1'b0;
      exp_gv = 1'b0; exp_gd = 8'h00;
      m_pend = 3'b000; m_active = 1'b0; ready = 0; m_last = 2;
    end else begin
      exp_start = (m_active && cyc == t_start) ? 3'(1 << owner) : 3'b000;
      exp_grant = m_active ? 3'(1 << owner) : 3'b000;
      exp_busy  = m_active || (cyc < ready);
      exp_to    = m_active && (cyc == t_start + TO) && !dn[owner];
    end
    chk("eng_start", bus.eng_start, exp_start);
    chk("grant", bus.grant, exp_grant);
    chk("pend", bus.pend, m_pend);
    chk("busy", bus.busy, exp_busy);
    chk("tx_timeout", bus.tx_timeout, exp_to);
    chk("gmii_valid", bus.gmii_txd_valid, exp_gv);
    chk("gmii_data", bus.gmii_txd_data, exp_gd);
    if (!rst_req) begin
      if (m_active && cyc > t_start) begin
        exp_gv = v[owner];
        exp_gd = d[8*owner +: 8];
      end else begin
        exp_gv = 1'b0;
        exp_gd = 8'h00;
      end
      if (m_active && cyc > t_start && (dn[owner] || cyc == t_start + TO)) begin
        m_active = 1'b0;
        ready    = cyc + IFG + 1;
      end
      if (!m_active && cyc >= ready && m_pend != 3'b000) begin
        owner    = pick_winner(m_pend, m_last);
        m_last   = owner;
        m_active = 1'b1;
        t_start  = cyc + 1;
      end
      m_pend = (m_pend & ~exp_start) | src;
    end
    es = bus.eng_start;
    if (bus.tx_timeout === 1'b1) timeouts_seen++;
    for (int i = 0; i < 3; i++) begin
      if (rst_req) e_run[i] = 1'b0;
      if (es[i] === 1'b1) begin
        e_run[i] = 1'b1;
        e_pos[i] = 0;
        starts_seen[i]++;
        last_start_cyc[i] = cyc;
        order_q.push_back(i);
        if (rand_len) e_len[i] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, 110);
      end
    end
    cyc++;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_idle(input int bound, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (!m_active && m_pend == 3'b000 && cyc >= ready) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    chk({"idle_reached_", tag}, 32'(ok), 32'd1);
  endtask

  initial begin
    int c0, base, t0;
    bus.src_start = 3'b000; bus.eng_done = 3'b000;
    bus.eng_txd_valid = 3'b000; bus.eng_txd_data = 24'h0;
    m_pend = 3'b000; m_active = 1'b0; t_start = 0; owner = 0; ready = 0; m_last = 2;
    exp_gv = 1'b0; exp_gd = 8'h00; timeouts_seen = 0;
    for (int i = 0; i < 3; i++) begin
      e_len[i] = 40; e_run[i] = 1'b0; e_pos[i] = 0;
      starts_seen[i] = 0; last_start_cyc[i] = 0;
    end

    // Reset state
    rst_req = 1'b1;
    cycles(3);
    rst_req = 1'b0;
    cycles(2);

    // Single ICMP request
    e_len[1] = 60;
    c0 = cyc;
    req = 3'b010;
    cycle();
    wait_idle(200, "icmp");
    chk("icmp_start_cycle", last_start_cyc[1], c0 + 2);
    chk("icmp_start_count", starts_seen[1], 1);

    // Simultaneous requests, second burst right after the first ARP grant
    e_len[0] = 25; e_len[1] = 33; e_len[2] = 41;
    order_q.delete();
    req = 3'b111;
    cycle();
    for (int k = 0; k < 10 && order_q.size() == 0; k++) cycle();
    req = 3'b111;
    cycle();
    wait_idle(800, "burst");
    chk("burst_count", order_q.size(), 4);
    for (int k = 0; k < 4 && k < order_q.size(); k++) chk("burst_order", order_q[k], exp_order[k]);

    // ARP requested twice during a UDP frame
    e_len[2] = 60;
    base = starts_seen[0];
    req = 3'b100;
    cycle();
    cycles(20);
    req = 3'b001;
    cycle();
    cycles(5);
    req = 3'b001;
    cycle();
    cycle();
    chk("pend_arp_in_send", bus.pend, 3'b001);
    wait_idle(300, "req_in_send");
    chk("arp_once", starts_seen[0] - base, 1);

    // ICMP engine never finishes; UDP waits behind it
    e_len[1] = NEVER;
    e_len[2] = 30;
    t0 = timeouts_seen;
    req = 3'b010;
    cycle();
    cycles(10);
    req = 3'b100;
    cycle();
    wait_idle(500, "timeout");
    chk("timeout_count", timeouts_seen - t0, 1);
    chk("udp_after_timeout", last_start_cyc[2] - last_start_cyc[1], TO + IFG + 2);

    // Done on the very last allowed SEND cycle
    e_len[1] = TO - 1;
    t0 = timeouts_seen;
    req = 3'b010;
    cycle();
    wait_idle(300, "done_at_limit");
    chk("done_beats_timeout", timeouts_seen - t0, 0);

    // Foreign done while ICMP is granted
    e_len[1] = 60;
    req = 3'b010;
    cycle();
    cycles(20);
    force_done = 3'b100;
    cycle();
    cycle();
    chk("icmp_still_granted", bus.grant, 3'b010);
    wait_idle(300, "foreign_done");

    // Reset in the middle of an ICMP frame with ARP pending
    e_len[1] = 60;
    req = 3'b010;
    cycle();
    for (int k = 0; k < 40 && e_pos[1] < 29; k++) cycle();
    req = 3'b001;
    cycle();
    rst_req = 1'b1;
    cycle();
    chk("rst_gmii_valid", bus.gmii_txd_valid, 1'b0);
    chk("rst_pend", bus.pend, 3'b000);
    chk("rst_busy", bus.busy, 1'b0);
    cycle();
    rst_req = 1'b0;
    base = starts_seen[0] + starts_seen[1] + starts_seen[2];
    cycles(30);
    chk("no_start_after_reset", starts_seen[0] + starts_seen[1] + starts_seen[2] - base, 0);

    // Randomized traffic with engine noise and random frame lengths
    noise_en = 1'b1;
    rand_len = 1'b1;
    for (int k = 0; k < 800; k++) begin
      req = ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000;
      cycle();
    end
    noise_en = 1'b0;
    rand_len = 1'b0;
    wait_idle(2000, "random");
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
